// File: rtl/intdiv_sd2conv.sv
// SD2 (radix-2 signed-digit) to two's-complement converter, MSD first.
// Uses on-the-fly Q/QM conversion so no carry-propagate adder is needed.
module intdiv_sd2conv #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   digit,
  output logic [N:0]   result,
  output logic         neg,
  output logic         zero,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [N:0]    ONE      = {{N{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [N:0]    q_q, q_d;
  logic [N:0]    qm_q, qm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    result_q, result_d;
  logic          neg_q, neg_d;
  logic          zero_q, zero_d;
  logic          out_valid_q, out_valid_d;

  logic          d_pos, d_neg;
  logic [N:0]    q_shift, qm_shift;

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    qm_d        = qm_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;

    d_pos    = (digit == 2'b10);
    d_neg    = (digit == 2'b01);
    q_shift  = q_q << 1;
    qm_shift = qm_q << 1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONV;
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
        end
      end

      S_CONV: begin
        if (in_valid) begin
          // QM = Q - 1 is kept as an invariant, so a -1 digit appends to QM
          // instead of borrowing through Q.
          if (d_pos) begin
            q_d  = q_shift | ONE;
            qm_d = q_shift;
          end else if (d_neg) begin
            q_d  = qm_shift | ONE;
            qm_d = qm_shift;
          end else begin
            q_d  = q_shift;
            qm_d = qm_shift | ONE;
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            result_d    = q_d;
            neg_d       = q_d[N];
            zero_d      = (q_d == '0);
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      qm_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      qm_q        <= qm_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_CONV);
  assign result    = result_q;
  assign neg       = neg_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_intdiv_sd2conv.sv
// Bench for intdiv_sd2conv (N=4): directed cases plus random digit strings
// compared against the weighted-sum value of the SD2 string.
module tb_intdiv_sd2conv;

  localparam int N = 4;

  typedef logic [1:0] dig_t [N];

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   digit;
  logic [N:0]   result;
  logic         neg;
  logic         zero;
  logic         out_valid;
  logic         out_ready;

  int checks   = 0;
  int failures = 0;

  intdiv_sd2conv #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .digit    (digit),
    .result   (result),
    .neg      (neg),
    .zero     (zero),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Value of an MSD-first SD2 string: sum of d_i * 2^(N-1-i).
  function automatic int sd_value(input dig_t dg);
    int v;
    v = 0;
    for (int i = 0; i < N; i++) begin
      if (dg[i] == 2'b10)      v += (1 << (N - 1 - i));
      else if (dg[i] == 2'b01) v -= (1 << (N - 1 - i));
    end
    return v;
  endfunction

  task automatic convert(input string tag, input dig_t dg, input int gap,
                         input int bp, input bit early);
    int v;
    logic [N:0] exp_r;
    v = sd_value(dg);
    exp_r = v[N:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".in_ready_start"}, in_ready, 1);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        digit    = 2'($urandom);
        start    = (g == 0);
        tick();
        start    = 1'b0;
        check({tag, ".in_ready_gap"}, in_ready, 1);
      end
      in_valid = 1'b1;
      digit    = dg[i];
      check({tag, ".out_valid_early"}, out_valid, 0);
      if (i == N - 1 && early) out_ready = 1'b1;
      tick();
    end
    // An extra digit and a start pulse arrive right after the last acceptance.
    digit = 2'($urandom);
    start = 1'b1;
    $display("conv %s value=%0d result=%0h neg=%0b zero=%0b", tag, v, result, neg, zero);
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".in_ready_done"}, in_ready, 0);
    check({tag, ".result"}, result, exp_r);
    check({tag, ".neg"}, neg, (v < 0));
    check({tag, ".zero"}, zero, (v == 0));
    if (early) begin
      tick();
      start = 1'b0;
      check({tag, ".one_cycle_valid"}, out_valid, 0);
    end else begin
      for (int b = 0; b < bp; b++) begin
        tick();
        start = 1'b0;
        check({tag, ".bp_valid"}, out_valid, 1);
        check({tag, ".bp_result"}, result, exp_r);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      tick();
      check({tag, ".valid_fall"}, out_valid, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    start     = 1'b0;
    check({tag, ".in_ready_idle"}, in_ready, 0);
    check({tag, ".result_hold"}, result, exp_r);
    tick();
    check({tag, ".still_idle"}, in_ready, 0);
  endtask

  initial begin
    dig_t dg;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; digit = 2'b00; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset.in_ready", in_ready, 0);
    check("reset.out_valid", out_valid, 0);
    check("reset.result", result, 0);
    check("reset.neg", neg, 0);
    check("reset.zero", zero, 0);

    dg = '{2'b10, 2'b00, 2'b01, 2'b10}; convert("p7", dg, 0, 0, 0);
    check("p7.literal", result, 5'b00111);
    dg = '{2'b01, 2'b01, 2'b01, 2'b01}; convert("m15", dg, 0, 1, 0);
    check("m15.literal", result, 5'b10001);
    dg = '{2'b10, 2'b10, 2'b10, 2'b10}; convert("p15", dg, 0, 0, 1);
    check("p15.literal", result, 5'b01111);
    dg = '{2'b00, 2'b11, 2'b11, 2'b00}; convert("zero", dg, 0, 0, 0);
    dg = '{2'b10, 2'b01, 2'b01, 2'b10}; convert("p3", dg, 0, 0, 0);
    check("p3.literal", result, 5'b00011);
    dg = '{2'b10, 2'b00, 2'b01, 2'b10}; convert("gap", dg, 2, 0, 0);
    dg = '{2'b01, 2'b10, 2'b00, 2'b01}; convert("bp5", dg, 0, 5, 0);

    // Reset mid-conversion after two digits.
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; digit = 2'b10; tick();
    digit = 2'b01; tick();
    in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    $display("reset_mid result=%0h out_valid=%0b in_ready=%0b", result, out_valid, in_ready);
    check("rstmid.in_ready", in_ready, 0);
    check("rstmid.out_valid", out_valid, 0);
    check("rstmid.result", result, 0);
    check("rstmid.neg", neg, 0);
    check("rstmid.zero", zero, 0);
    dg = '{2'b00, 2'b10, 2'b11, 2'b10}; convert("after_rst", dg, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) dg[i] = 2'($urandom);
      convert($sformatf("rnd%0d", t), dg, $urandom_range(0, 2),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
